// File: rtl/tluh_32_pkg.sv
// TL-UL (32-bit data, 8-bit source id) channel types shared by hosts and devices.
// Pure type/constant package: no logic, no latency.
package tluh_32_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic               a_valid;
        tl_a_op_e           a_opcode;
        logic [2:0]         a_param;
        logic [TL_SZW-1:0]  a_size;
        logic [TL_AIW-1:0]  a_source;
        logic [TL_AW-1:0]   a_address;
        logic [TL_DBW-1:0]  a_mask;
        logic [TL_DW-1:0]   a_data;
        logic               d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic               d_valid;
        tl_d_op_e           d_opcode;
        logic [2:0]         d_param;
        logic [TL_SZW-1:0]  d_size;
        logic [TL_AIW-1:0]  d_source;
        logic [TL_DIW-1:0]  d_sink;
        logic [TL_DW-1:0]   d_data;
        logic               d_error;
        logic               a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_socket_1n_pkg.sv
// Peripheral cluster address map: device count, per-device base/mask windows
// and the default in-flight request limit used by the 1:N socket.
package tlul_socket_1n_pkg;

    localparam int unsigned NUM_DEV         = 4;
    localparam int unsigned MAX_OUTSTANDING = 4;

    // Packed arrays list the highest index first: device 0 is the rightmost entry.
    localparam logic [NUM_DEV-1:0][31:0] DEV_BASE = {
        32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000
    };
    localparam logic [NUM_DEV-1:0][31:0] DEV_MASK = {NUM_DEV{32'hFFFF_0000}};

    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/tlul_err_resp.sv
// Error responder for unmapped addresses: one request at a time, d_error=1, all-ones data.
// Latency 1 cycle accept->d_valid; a_ready drops while a response waits for d_ready.
module tlul_err_resp
    import tluh_32_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o
);

    logic                r_pending;
    tl_a_op_e            r_opcode;
    logic [TL_SZW-1:0]   r_size;
    logic [TL_AIW-1:0]   r_source;
    logic                w_accept;
    logic                w_ret;
    logic                w_unused;

    assign w_accept = rst_ni && tl_h_i.a_valid && !r_pending;
    assign w_ret    = r_pending && tl_h_i.d_ready;
    assign w_unused = ^{tl_h_i.a_param, tl_h_i.a_address, tl_h_i.a_mask, tl_h_i.a_data};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pending <= 1'b0;
            r_opcode  <= PutFullData;
            r_size    <= '0;
            r_source  <= '0;
        end else begin
            if (w_accept) begin
                r_pending <= 1'b1;
                r_opcode  <= tl_h_i.a_opcode;
                r_size    <= tl_h_i.a_size;
                r_source  <= tl_h_i.a_source;
            end else if (w_ret) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        tl_h_o          = '0;
        tl_h_o.a_ready  = rst_ni && !r_pending;
        tl_h_o.d_valid  = r_pending;
        tl_h_o.d_opcode = (r_opcode == Get) ? AccessAckData : AccessAck;
        tl_h_o.d_size   = r_size;
        tl_h_o.d_source = r_source;
        tl_h_o.d_data   = '1;
        tl_h_o.d_error  = 1'b1;
    end

endmodule

// File: rtl/tlul_socket_1n.sv
// 1-host to N-device TL-UL demux with an internal error port for unmapped addresses.
// Zero added latency on A and D; requests stall while a different destination is in flight.
module tlul_socket_1n
    import tluh_32_pkg::*;
    import tlul_socket_1n_pkg::*;
#(
    parameter int unsigned          N              = NUM_DEV,
    parameter int unsigned          MaxOutstanding = MAX_OUTSTANDING,
    parameter logic [N-1:0][31:0]   DevBase        = DEV_BASE,
    parameter logic [N-1:0][31:0]   DevMask        = DEV_MASK
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o,
    output tl_h2d_t tl_d_o [N],
    input  tl_d2h_t tl_d_i [N]
);

    localparam int OW = $clog2(MaxOutstanding + 1);
    localparam int SW = $clog2(N + 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(MaxOutstanding);
    localparam logic [SW-1:0] ERR_IDX = SW'(N);

    logic [SW-1:0] w_dev_sel;
    logic [SW-1:0] r_dev_select;
    logic [OW-1:0] r_outstanding;
    logic          w_hold;
    logic          w_accept;
    logic          w_ret;
    tl_h2d_t       w_err_req;
    tl_d2h_t       w_err_rsp;
    tl_d2h_t       w_dev_rsp [N+1];

    // Lowest matching index wins, so scan downward and let later hits overwrite.
    always_comb begin
        w_dev_sel = ERR_IDX;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (addr_hit(tl_h_i.a_address, DevBase[i], DevMask[i])) begin
                w_dev_sel = SW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_dev_rsp[i] = tl_d_i[i];
        end
        w_dev_rsp[N] = w_err_rsp;
    end

    assign w_hold = (r_outstanding != '0) &&
                    ((w_dev_sel != r_dev_select) || (r_outstanding == MAX_CNT));

    always_comb begin
        tl_h_o         = w_dev_rsp[r_dev_select];
        tl_h_o.a_ready = !rst_i && w_dev_rsp[w_dev_sel].a_ready && !w_hold;
        tl_h_o.d_valid = !rst_i && w_dev_rsp[r_dev_select].d_valid;
    end

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            tl_d_o[i]         = tl_h_i;
            tl_d_o[i].a_valid = !rst_i && tl_h_i.a_valid && (w_dev_sel == SW'(i)) && !w_hold;
            tl_d_o[i].d_ready = !rst_i && tl_h_i.d_ready && (r_dev_select == SW'(i));
        end
        w_err_req         = tl_h_i;
        w_err_req.a_valid = !rst_i && tl_h_i.a_valid && (w_dev_sel == ERR_IDX) && !w_hold;
        w_err_req.d_ready = !rst_i && tl_h_i.d_ready && (r_dev_select == ERR_IDX);
    end

    assign w_accept = tl_h_i.a_valid && tl_h_o.a_ready;
    assign w_ret    = tl_h_o.d_valid && tl_h_i.d_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
            r_dev_select  <= '0;
        end else begin
            if (w_accept) begin
                r_dev_select <= w_dev_sel;
            end
            case ({w_accept, w_ret})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    tlul_err_resp u_err_resp (
        .clk_i  (clk_i),
        .rst_ni (~rst_i),
        .tl_h_i (w_err_req),
        .tl_h_o (w_err_rsp)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i <= int'(N); i++) begin
                assert (r_outstanding == '0 || SW'(i) == r_dev_select || !w_dev_rsp[i].d_valid);
            end
            assert (r_outstanding != '0 || !tl_h_o.d_valid);
        end
        for (int i = 0; i < int'(N); i++) begin
            assert ((DevBase[i] & ~DevMask[i]) == '0);
        end
    end
`endif

endmodule

// File: tb/tb_tlul_socket_1n.sv
// Directed bench for the 1:N TL-UL socket: decode, error port, outstanding limit,
// destination switching, D-channel backpressure and mid-transaction reset.
module tb_tlul_socket_1n;
    import tluh_32_pkg::*;

    logic    clk;
    logic    rst;
    tl_h2d_t tl_h_i;
    tl_d2h_t tl_h_o;
    tl_h2d_t tl_d_o [4];
    tl_d2h_t tl_d_i [4];
    logic [3:0] dev_av;
    logic [3:0] dev_dr;
    int n_checks = 0;
    int n_fail   = 0;

    tlul_socket_1n dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tl_h_i (tl_h_i),
        .tl_h_o (tl_h_o),
        .tl_d_o (tl_d_o),
        .tl_d_i (tl_d_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dev_av = {tl_d_o[3].a_valid, tl_d_o[2].a_valid, tl_d_o[1].a_valid, tl_d_o[0].a_valid};
    assign dev_dr = {tl_d_o[3].d_ready, tl_d_o[2].d_ready, tl_d_o[1].d_ready, tl_d_o[0].d_ready};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_req(input tl_a_op_e op, input logic [31:0] addr, input logic [7:0] src);
        tl_h_i.a_valid   = 1'b1;
        tl_h_i.a_opcode  = op;
        tl_h_i.a_address = addr;
        tl_h_i.a_source  = src;
        tl_h_i.a_size    = 2'd2;
        tl_h_i.a_mask    = 4'hF;
        tl_h_i.a_data    = addr ^ 32'h5A5A_5A5A;
    endtask

    task automatic host_idle();
        tl_h_i.a_valid = 1'b0;
    endtask

    task automatic dev_rsp(input int i, input logic [31:0] data, input logic [7:0] src);
        tl_d_i[i].d_valid  = 1'b1;
        tl_d_i[i].d_opcode = AccessAckData;
        tl_d_i[i].d_data   = data;
        tl_d_i[i].d_source = src;
        tl_d_i[i].d_size   = 2'd2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        host_req(Get, 32'h0001_0000, 8'h01);
        tl_d_i[0].d_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, tl_h_o.d_valid, dev_av, dev_dr} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_forced: got a_rdy=%b d_vld=%b av=%b dr=%b, want all 0",
                     tl_h_o.a_ready, tl_h_o.d_valid, dev_av, dev_dr);
        end
        tick();
        rst = 1'b0;
        host_idle();
        tl_d_i[0].d_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dut.r_outstanding, dut.r_dev_select} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got outstanding=%0d sel=%0d, want 0/0",
                     dut.r_outstanding, dut.r_dev_select);
        end
    endtask

    task automatic test_get_dev1();
        tick();
        host_req(Get, 32'h0001_0004, 8'h05);
        @(negedge clk);
        n_checks++;
        if ({dev_av, tl_h_o.a_ready} !== {4'b0010, 1'b1}) begin
            n_fail++;
            $display("FAIL get1_route: got av=%b a_rdy=%b, want 0010/1", dev_av, tl_h_o.a_ready);
        end
        tick();
        host_idle();
        dev_rsp(1, 32'hCAFE_0001, 8'h05);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.d_valid, tl_h_o.d_data, tl_h_o.d_source} !== {1'b1, 32'hCAFE_0001, 8'h05}) begin
            n_fail++;
            $display("FAIL get1_resp: got vld=%b data=%h src=%h, want 1/cafe0001/05",
                     tl_h_o.d_valid, tl_h_o.d_data, tl_h_o.d_source);
        end
        n_checks++;
        if ({dev_dr, dut.r_outstanding} !== {4'b0010, 3'd1}) begin
            n_fail++;
            $display("FAIL get1_dready: got dr=%b outst=%0d, want 0010/1", dev_dr, dut.r_outstanding);
        end
        tick();
        tl_d_i[1].d_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.d_valid, dut.r_outstanding} !== 4'b0) begin
            n_fail++;
            $display("FAIL get1_drain: got vld=%b outst=%0d, want 0/0", tl_h_o.d_valid, dut.r_outstanding);
        end
    endtask

    task automatic test_unmapped();
        tick();
        host_req(PutFullData, 32'h0010_0000, 8'h09);
        @(negedge clk);
        n_checks++;
        if ({dev_av, tl_h_o.a_ready} !== {4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL err_put_route: got av=%b a_rdy=%b, want 0000/1", dev_av, tl_h_o.a_ready);
        end
        tick();
        host_idle();
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.d_valid, tl_h_o.d_error, tl_h_o.d_opcode, tl_h_o.d_source} !==
            {1'b1, 1'b1, AccessAck, 8'h09}) begin
            n_fail++;
            $display("FAIL err_put_resp: got vld=%b err=%b op=%0d src=%h, want 1/1/0/09",
                     tl_h_o.d_valid, tl_h_o.d_error, tl_h_o.d_opcode, tl_h_o.d_source);
        end
        tick();
        host_req(Get, 32'h0010_0000, 8'h03);
        @(negedge clk);
        n_checks++;
        if (tl_h_o.a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_get_ardy: got %b want 1", tl_h_o.a_ready);
        end
        tick();
        host_idle();
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.d_valid, tl_h_o.d_error, tl_h_o.d_opcode, tl_h_o.d_data, tl_h_o.d_source} !==
            {1'b1, 1'b1, AccessAckData, 32'hFFFF_FFFF, 8'h03}) begin
            n_fail++;
            $display("FAIL err_get_resp: got vld=%b err=%b op=%0d data=%h src=%h, want 1/1/1/ffffffff/03",
                     tl_h_o.d_valid, tl_h_o.d_error, tl_h_o.d_opcode, tl_h_o.d_data, tl_h_o.d_source);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (dut.r_outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL err_drain: got outst=%0d want 0", dut.r_outstanding);
        end
    endtask

    task automatic test_max_outstanding();
        for (int k = 0; k < 4; k++) begin
            tick();
            host_req(Get, 32'h0002_0000 + 32'(4 * k), 8'(k));
            @(negedge clk);
            n_checks++;
            if ({tl_h_o.a_ready, dev_av} !== {1'b1, 4'b0100}) begin
                n_fail++;
                $display("FAIL max_accept_%0d: got a_rdy=%b av=%b, want 1/0100", k, tl_h_o.a_ready, dev_av);
            end
        end
        tick();
        host_req(Get, 32'h0002_0010, 8'h04);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, dev_av, dut.r_outstanding} !== {1'b0, 4'b0000, 3'd4}) begin
            n_fail++;
            $display("FAIL max_stall: got a_rdy=%b av=%b outst=%0d, want 0/0000/4",
                     tl_h_o.a_ready, dev_av, dut.r_outstanding);
        end
        tick();
        dev_rsp(2, 32'h2000_0000, 8'h00);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, tl_h_o.d_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL max_release: got a_rdy=%b d_vld=%b, want 0/1", tl_h_o.a_ready, tl_h_o.d_valid);
        end
        tick();
        tl_d_i[2].d_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, dev_av, dut.r_outstanding} !== {1'b1, 4'b0100, 3'd3}) begin
            n_fail++;
            $display("FAIL max_fifth: got a_rdy=%b av=%b outst=%0d, want 1/0100/3",
                     tl_h_o.a_ready, dev_av, dut.r_outstanding);
        end
        tick();
        host_idle();
        @(negedge clk);
        n_checks++;
        if (dut.r_outstanding !== 3'd4) begin
            n_fail++;
            $display("FAIL max_refill: got outst=%0d want 4", dut.r_outstanding);
        end
        dev_rsp(2, 32'h2000_0001, 8'h01);
        repeat (4) tick();
        tl_d_i[2].d_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.r_outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL max_drain: got outst=%0d want 0", dut.r_outstanding);
        end
    endtask

    task automatic test_switch();
        tick();
        host_req(Get, 32'h0000_0020, 8'h07);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, dev_av} !== {1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL sw_dev0: got a_rdy=%b av=%b, want 1/0001", tl_h_o.a_ready, dev_av);
        end
        tick();
        host_req(Get, 32'h0003_0010, 8'h08);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, dev_av} !== {1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL sw_stall: got a_rdy=%b av=%b, want 0/0000", tl_h_o.a_ready, dev_av);
        end
        tick();
        dev_rsp(0, 32'h0D0D_0000, 8'h07);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, tl_h_o.d_valid, tl_h_o.d_data} !== {1'b0, 1'b1, 32'h0D0D_0000}) begin
            n_fail++;
            $display("FAIL sw_dev0_resp: got a_rdy=%b vld=%b data=%h, want 0/1/0d0d0000",
                     tl_h_o.a_ready, tl_h_o.d_valid, tl_h_o.d_data);
        end
        tick();
        tl_d_i[0].d_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, dev_av, dut.r_outstanding} !== {1'b1, 4'b1000, 3'd0}) begin
            n_fail++;
            $display("FAIL sw_dev3_accept: got a_rdy=%b av=%b outst=%0d, want 1/1000/0",
                     tl_h_o.a_ready, dev_av, dut.r_outstanding);
        end
        tick();
        host_idle();
        dev_rsp(3, 32'h3333_0003, 8'h08);
        @(negedge clk);
        n_checks++;
        if ({dut.r_dev_select, tl_h_o.d_valid, tl_h_o.d_data} !== {3'd3, 1'b1, 32'h3333_0003}) begin
            n_fail++;
            $display("FAIL sw_dev3_resp: got sel=%0d vld=%b data=%h, want 3/1/33330003",
                     dut.r_dev_select, tl_h_o.d_valid, tl_h_o.d_data);
        end
        tick();
        tl_d_i[3].d_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.r_outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL sw_drain: got outst=%0d want 0", dut.r_outstanding);
        end
    endtask

    task automatic test_d_backpressure();
        tick();
        host_req(Get, 32'h0001_0008, 8'h02);
        tick();
        host_idle();
        tl_h_i.d_ready = 1'b0;
        dev_rsp(1, 32'h1234_5678, 8'h02);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({tl_h_o.d_valid, tl_h_o.d_data, dev_dr, dut.r_outstanding} !==
                {1'b1, 32'h1234_5678, 4'b0000, 3'd1}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b data=%h dr=%b outst=%0d, want 1/12345678/0000/1",
                         k, tl_h_o.d_valid, tl_h_o.d_data, dev_dr, dut.r_outstanding);
            end
            tick();
        end
        tl_h_i.d_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.d_valid, dev_dr} !== {1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b dr=%b, want 1/0010", tl_h_o.d_valid, dev_dr);
        end
        tick();
        tl_d_i[1].d_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.r_outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_drain: got outst=%0d want 0", dut.r_outstanding);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        host_req(Get, 32'h0001_0000, 8'h01);
        tick();
        host_req(Get, 32'h0001_0004, 8'h02);
        tick();
        rst = 1'b1;
        host_req(Get, 32'h0001_0008, 8'h03);
        dev_rsp(1, 32'hDEAD_0001, 8'h01);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, tl_h_o.d_valid, dev_av, dev_dr, dut.r_outstanding} !== {10'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL rstmid_forced: got a_rdy=%b vld=%b av=%b dr=%b outst=%0d, want 0/0/0000/0000/2",
                     tl_h_o.a_ready, tl_h_o.d_valid, dev_av, dev_dr, dut.r_outstanding);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({dut.r_outstanding, dut.r_dev_select, tl_h_o.a_ready, tl_h_o.d_valid, dev_av, dev_dr} !== 16'b0) begin
            n_fail++;
            $display("FAIL rstmid_state: got outst=%0d sel=%0d a_rdy=%b vld=%b av=%b dr=%b, want all 0",
                     dut.r_outstanding, dut.r_dev_select, tl_h_o.a_ready, tl_h_o.d_valid, dev_av, dev_dr);
        end
        tick();
        rst = 1'b0;
        host_idle();
        tl_d_i[1].d_valid = 1'b0;
        tick();
        host_req(Get, 32'h0001_000C, 8'h04);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.a_ready, dev_av} !== {1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL rstmid_fresh_req: got a_rdy=%b av=%b, want 1/0010", tl_h_o.a_ready, dev_av);
        end
        tick();
        host_idle();
        dev_rsp(1, 32'hBEEF_0004, 8'h04);
        @(negedge clk);
        n_checks++;
        if ({tl_h_o.d_valid, tl_h_o.d_data} !== {1'b1, 32'hBEEF_0004}) begin
            n_fail++;
            $display("FAIL rstmid_fresh_resp: got vld=%b data=%h, want 1/beef0004",
                     tl_h_o.d_valid, tl_h_o.d_data);
        end
        tick();
        tl_d_i[1].d_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.r_outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_drain: got outst=%0d want 0", dut.r_outstanding);
        end
    endtask

    initial begin
        rst = 1'b1;
        tl_h_i = '0;
        tl_h_i.d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tl_d_i[i] = '0;
            tl_d_i[i].a_ready = 1'b1;
        end
        test_reset();
        test_get_dev1();
        test_unmapped();
        test_max_outstanding();
        test_switch();
        test_d_backpressure();
        test_reset_mid();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
